// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: captures a decoded branch, evaluates its condition on
// forwarded operands, redirects the PC / squashes wrong-path work, and keeps branch statistics.
module branch_resolver #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic [5:0]       id_opcode,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_rs_val,
    input  logic [XLEN-1:0]  id_rt_val,
    input  logic             stall,
    input  logic             cnt_clr,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_BLT = 6'b000110;
    localparam logic [5:0] OP_BGE = 6'b000111;
    localparam logic [5:0] OP_BLE = 6'b001010;
    localparam logic [5:0] OP_BGT = 6'b001011;

    logic            ex_valid;
    logic [5:0]      ex_opcode;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs;
    logic [XLEN-1:0] ex_rt;

    logic            legal;
    logic            cond;
    logic            taken;
    logic            resolve;
    logic [XLEN-1:0] target;

    always_comb begin
        legal = 1'b1;
        cond  = 1'b0;
        case (ex_opcode)
            OP_BEQ:  cond = (ex_rs == ex_rt);
            OP_BNE:  cond = (ex_rs != ex_rt);
            OP_BLT:  cond = ($signed(ex_rs) <  $signed(ex_rt));
            OP_BGE:  cond = ($signed(ex_rs) >= $signed(ex_rt));
            OP_BLE:  cond = ($signed(ex_rs) <= $signed(ex_rt));
            OP_BGT:  cond = ($signed(ex_rs) >  $signed(ex_rt));
            default: legal = 1'b0;
        endcase
    end

    assign taken   = ex_valid & legal & cond;
    assign resolve = ex_valid & legal & ~stall;
    // Word offset relative to the next sequential PC; overflow wraps silently.
    assign target  = ex_pc + XLEN'(4) + (ex_imm << 2);

    assign redirect_valid = resolve & taken;
    assign flush_if       = resolve & taken;
    assign flush_id       = resolve & taken;
    assign redirect_pc    = ex_valid ? target : '0;

    // A branch seen in decode while a redirect fires is wrong-path and never enters EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_opcode <= '0;
            ex_pc     <= '0;
            ex_imm    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
        end else if (!stall) begin
            ex_valid  <= id_valid & id_is_branch & ~redirect_valid;
            ex_opcode <= id_opcode;
            ex_pc     <= id_pc;
            ex_imm    <= id_imm;
            ex_rs     <= id_rs_val;
            ex_rt     <= id_rt_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (cnt_clr) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (resolve) begin
            if (branch_count != '1)
                branch_count <= branch_count + CNT_W'(1);
            if (taken && (taken_count != '1))
                taken_count <= taken_count + CNT_W'(1);
        end
    end

endmodule
